// File: rtl/intr_ctrl_if.sv
// Bundle of the interrupt controller's CPU-side signals: raw sources, the EXE-stage
// register port and the CP0 request/acknowledge handshake.
interface intr_ctrl_if #(
    parameter int N_SRC = 8
);
    logic [N_SRC-1:0] src;
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [31:0]      cfg_wdata;
    logic [31:0]      cfg_rdata;
    logic             ir_out;
    logic             ack;
    logic             eret;
    logic [2:0]       cause;
    logic             busy;

    // The CPU side drives sources, register accesses and CP0 events.
    modport master (
        output src, cfg_we, cfg_addr, cfg_wdata, ack, eret,
        input  cfg_rdata, ir_out, cause, busy
    );

    modport slave (
        input  src, cfg_we, cfg_addr, cfg_wdata, ack, eret,
        output cfg_rdata, ir_out, cause, busy
    );
endinterface

// File: rtl/intr_ctrl.sv
// Prioritised interrupt controller: synchronises raw lines, tracks edge/level pending
// state, and keeps exactly one interrupt outstanding towards CP0 from request to ERET.
module intr_ctrl #(
    parameter int N_SRC = 8
) (
    input  logic        clk,
    input  logic        rst,
    intr_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    logic [N_SRC-1:0] r_s1;
    logic [N_SRC-1:0] r_s2;
    logic [N_SRC-1:0] r_s3;
    logic [N_SRC-1:0] r_mask;
    logic [N_SRC-1:0] r_edgeMode;
    logic [N_SRC-1:0] r_pend;
    state_t           r_state;
    logic             r_irOut;
    logic             r_busy;
    logic [2:0]       r_cause;

    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_eligible;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_pendNext;
    logic [2:0]       w_winner;
    logic             w_w1c;
    logic             w_maskWr;
    logic             w_edgeWr;
    state_t           w_stateNext;
    logic             w_latchCause;
    logic             w_ackTaken;
    logic             w_unused;

    assign w_maskWr = bus.cfg_we && (bus.cfg_addr == 2'd0);
    assign w_edgeWr = bus.cfg_we && (bus.cfg_addr == 2'd1);
    assign w_w1c    = bus.cfg_we && (bus.cfg_addr == 2'd2);
    assign w_unused = ^bus.cfg_wdata[31:N_SRC];

    assign w_rise     = r_s2 & ~r_s3;
    assign w_eligible = r_pend & r_mask;

    // Two-flop synchroniser plus one history flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= bus.src;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Fixed priority: scanning downwards lets the lowest eligible index win.
    always_comb begin
        w_winner = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = 3'(i);
            end
        end
    end

    always_comb begin
        w_clr      = '0;
        w_pendNext = r_pend;
        for (int i = 0; i < N_SRC; i++) begin
            w_clr[i] = (w_w1c && bus.cfg_wdata[i]) ||
                       (w_ackTaken && (r_cause == 3'(i)));
            // A new edge in the same cycle as a clear keeps the bit set.
            if (r_edgeMode[i]) begin
                w_pendNext[i] = (r_pend[i] & ~w_clr[i]) | w_rise[i];
            end else begin
                w_pendNext[i] = r_s2[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask     <= '0;
            r_edgeMode <= '0;
            r_pend     <= '0;
        end else begin
            if (w_maskWr) begin
                r_mask <= bus.cfg_wdata[N_SRC-1:0];
            end
            if (w_edgeWr) begin
                r_edgeMode <= bus.cfg_wdata[N_SRC-1:0];
            end
            r_pend <= w_pendNext;
        end
    end

    // Once in REQ the request is committed; only ack moves it on, so later mask
    // or pending changes cannot withdraw an interrupt CP0 may already be taking.
    always_comb begin
        w_stateNext  = r_state;
        w_latchCause = 1'b0;
        w_ackTaken   = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_eligible) begin
                    w_stateNext  = REQ;
                    w_latchCause = 1'b1;
                end
            end
            REQ: begin
                if (bus.ack) begin
                    w_stateNext = SERV;
                    w_ackTaken  = 1'b1;
                end
            end
            SERV: begin
                if (bus.eret) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_irOut <= 1'b0;
            r_busy  <= 1'b0;
            r_cause <= 3'd0;
        end else begin
            r_state <= w_stateNext;
            r_irOut <= (w_stateNext == REQ);
            r_busy  <= (w_stateNext == SERV);
            if (w_latchCause) begin
                r_cause <= w_winner;
            end
        end
    end

    always_comb begin
        bus.cfg_rdata = 32'd0;
        case (bus.cfg_addr)
            2'd0:    bus.cfg_rdata = 32'(r_mask);
            2'd1:    bus.cfg_rdata = 32'(r_edgeMode);
            2'd2:    bus.cfg_rdata = 32'(r_pend);
            default: bus.cfg_rdata = {27'd0, r_busy, r_irOut, r_cause};
        endcase
    end

    assign bus.ir_out = r_irOut;
    assign bus.busy   = r_busy;
    assign bus.cause  = r_cause;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: hand-computed expectations checked with immediate
// assertions after each clock edge.
`timescale 1ns/1ps
module tb_intr_ctrl;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    intr_ctrl_if #(.N_SRC(8)) bus ();

    intr_ctrl #(.N_SRC(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] src, input logic ack, input logic eret);
        bus.src  = src;
        bus.ack  = ack;
        bus.eret = eret;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkReg(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        bus.cfg_addr = addr;
        #1;
        checkOutput(tag, bus.cfg_rdata, exp);
    endtask

    task automatic checkStatus(input string tag, input logic ir, input logic busy, input logic [2:0] cause);
        checkOutput({tag, ".ir_out"}, 32'(bus.ir_out), 32'(ir));
        checkOutput({tag, ".busy"},   32'(bus.busy),   32'(busy));
        checkOutput({tag, ".cause"},  32'(bus.cause),  32'(cause));
    endtask

    task automatic cfgWrite(input logic [1:0] addr, input logic [31:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        tick(1);
        bus.cfg_we    = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst           = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = 2'd0;
        bus.cfg_wdata = 32'd0;
        applyStimulus(8'h00, 1'b0, 1'b0);
        tick(2);
        rst = 1'b0;

        $display("[TB] reset state");
        checkReg("rst.mask", 2'd0, 32'h0);
        checkReg("rst.edge", 2'd1, 32'h0);
        checkReg("rst.pend", 2'd2, 32'h0);
        tick(1);
        checkReg("rst.status", 2'd3, 32'h0);
        checkStatus("rst", 1'b0, 1'b0, 3'd0);

        $display("[TB] single edge source 0");
        cfgWrite(2'd0, 32'h01);
        cfgWrite(2'd1, 32'h01);
        applyStimulus(8'h01, 1'b0, 1'b0);
        tick(1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        tick(1);
        checkReg("e0.pend_k1", 2'd2, 32'h00);
        tick(1);
        checkReg("e0.pend_k2", 2'd2, 32'h01);
        checkStatus("e0.k2", 1'b0, 1'b0, 3'd0);
        tick(1);
        checkStatus("e0.req", 1'b1, 1'b0, 3'd0);
        checkReg("e0.status_req", 2'd3, 32'h08);
        applyStimulus(8'h00, 1'b1, 1'b0);
        tick(1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkStatus("e0.serv", 1'b0, 1'b1, 3'd0);
        checkReg("e0.pend_serv", 2'd2, 32'h00);
        applyStimulus(8'h00, 1'b0, 1'b1);
        tick(1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkStatus("e0.eret", 1'b0, 1'b0, 3'd0);
        tick(1);
        checkStatus("e0.idle", 1'b0, 1'b0, 3'd0);

        $display("[TB] priority between sources 5 and 2");
        cfgWrite(2'd1, 32'hFF);
        cfgWrite(2'd0, 32'hFF);
        applyStimulus(8'h24, 1'b0, 1'b0);
        tick(3);
        checkReg("pri.pend", 2'd2, 32'h24);
        tick(1);
        checkStatus("pri.req2", 1'b1, 1'b0, 3'd2);
        applyStimulus(8'h00, 1'b1, 1'b0);
        tick(1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkStatus("pri.serv2", 1'b0, 1'b1, 3'd2);
        checkReg("pri.pend_after_ack2", 2'd2, 32'h20);
        applyStimulus(8'h00, 1'b0, 1'b1);
        tick(1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkStatus("pri.eret2", 1'b0, 1'b0, 3'd2);
        tick(1);
        checkStatus("pri.req5", 1'b1, 1'b0, 3'd5);
        applyStimulus(8'h00, 1'b1, 1'b0);
        tick(1);
        applyStimulus(8'h00, 1'b0, 1'b1);
        tick(1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkReg("pri.pend_clear", 2'd2, 32'h00);
        tick(1);
        checkStatus("pri.idle", 1'b0, 1'b0, 3'd5);
        cfgWrite(2'd3, 32'hFFFF_FFFF);
        checkReg("pri.status_ro", 2'd3, 32'h05);

        $display("[TB] level mode source 3");
        cfgWrite(2'd1, 32'h00);
        cfgWrite(2'd0, 32'h08);
        applyStimulus(8'h08, 1'b0, 1'b0);
        tick(3);
        checkReg("lvl.pend", 2'd2, 32'h08);
        tick(1);
        checkStatus("lvl.req1", 1'b1, 1'b0, 3'd3);
        applyStimulus(8'h08, 1'b1, 1'b0);
        tick(1);
        applyStimulus(8'h08, 1'b0, 1'b0);
        checkReg("lvl.pend_after_ack", 2'd2, 32'h08);
        applyStimulus(8'h08, 1'b0, 1'b1);
        tick(1);
        applyStimulus(8'h08, 1'b0, 1'b0);
        checkStatus("lvl.eret1", 1'b0, 1'b0, 3'd3);
        tick(1);
        checkStatus("lvl.req2", 1'b1, 1'b0, 3'd3);
        applyStimulus(8'h08, 1'b1, 1'b0);
        tick(1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        tick(2);
        checkReg("lvl.pend_drop2", 2'd2, 32'h08);
        tick(1);
        checkReg("lvl.pend_drop3", 2'd2, 32'h00);
        applyStimulus(8'h00, 1'b0, 1'b1);
        tick(1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkStatus("lvl.eret2", 1'b0, 1'b0, 3'd3);
        tick(2);
        checkStatus("lvl.quiet", 1'b0, 1'b0, 3'd3);

        $display("[TB] committed request on source 1");
        cfgWrite(2'd1, 32'h02);
        cfgWrite(2'd0, 32'h02);
        applyStimulus(8'h02, 1'b0, 1'b0);
        tick(1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        tick(3);
        checkStatus("cmt.req", 1'b1, 1'b0, 3'd1);
        checkReg("cmt.status", 2'd3, 32'h09);
        cfgWrite(2'd0, 32'h00);
        cfgWrite(2'd2, 32'h02);
        checkReg("cmt.pend_w1c", 2'd2, 32'h00);
        checkStatus("cmt.held", 1'b1, 1'b0, 3'd1);
        tick(1);
        checkStatus("cmt.held2", 1'b1, 1'b0, 3'd1);
        applyStimulus(8'h00, 1'b1, 1'b1);
        tick(1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkStatus("cmt.ack_eret", 1'b0, 1'b1, 3'd1);
        tick(1);
        checkStatus("cmt.still_serv", 1'b0, 1'b1, 3'd1);
        applyStimulus(8'h00, 1'b0, 1'b1);
        tick(1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkStatus("cmt.eret", 1'b0, 1'b0, 3'd1);

        $display("[TB] reset while in service");
        cfgWrite(2'd1, 32'h32);
        cfgWrite(2'd0, 32'h02);
        applyStimulus(8'h02, 1'b0, 1'b0);
        tick(1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        tick(3);
        applyStimulus(8'h00, 1'b1, 1'b0);
        tick(1);
        applyStimulus(8'h30, 1'b0, 1'b0);
        tick(1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        tick(2);
        checkReg("rs.pend_before", 2'd2, 32'h30);
        checkReg("rs.status_before", 2'd3, 32'h11);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkReg("rs.mask", 2'd0, 32'h0);
        checkReg("rs.edge", 2'd1, 32'h0);
        checkReg("rs.pend", 2'd2, 32'h0);
        checkStatus("rs.out", 1'b0, 1'b0, 3'd0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        tick(1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkStatus("rs.stray_ack", 1'b0, 1'b0, 3'd0);
        applyStimulus(8'h00, 1'b0, 1'b1);
        tick(1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkStatus("rs.stray_eret", 1'b0, 1'b0, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Prioritised interrupt controller sitting between external interrupt lines and the CP0 interrupt input of the pipelined CPU. It synchronises up to 8 raw sources, supports per-source edge/level mode, mask and pending bits, and keeps the request to CP0 asserted until CP0 acknowledges entry. It then holds the in-service state until ERET, so exactly one interrupt is outstanding at a time. Its configuration registers are written and read through a small register port driven from the EXE stage.

## Interface
- N_SRC, 8, number of interrupt sources (1..8); cause field is 3 bits regardless.
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- src  in  N_SRC  raw asynchronous interrupt lines, active-high
- cfg_we  in  1  register write strobe
- cfg_addr  in  2  register select: 0 MASK, 1 EDGE, 2 PEND, 3 STATUS
- cfg_wdata  in  32  write data; bits [N_SRC-1:0] used
- cfg_rdata  out  32  combinational read of the cfg_addr register, zero-extended
- ir_out  out  1  interrupt request to CP0 ir_in, registered
- ack  in  1  CP0 interrupt entry taken (CP0 jump_en caused by interrupt)
- eret  in  1  CP0 executed ERET
- cause  out  3  index of the source being requested or serviced, registered
- busy  out  1  an interrupt is in service, registered

## Operation
- Registers: MASK (1 = enabled) and EDGE (1 = rising-edge, 0 = level) are read/write. PEND is read-only except write-1-to-clear. STATUS reads {27'b0, busy, ir_out, cause}, and writes to it are ignored. All reset to 0.
- Each src bit passes through 2 flops (s1, s2) and a third flop (s3) holds the previous s2.
- Edge mode: s2 & ~s3 sets PEND[i]. The bit stays set until a W1C write or an ack that selects i. If set and clear coincide, set wins.
- Level mode: PEND[i] = s2, updated every cycle. W1C and ack have no lasting effect.
- Eligible = PEND & MASK. Selection is fixed priority, lowest index wins.
- FSM, states IDLE / REQ / SERV:
  - IDLE: if eligible != 0, latch cause = winner, go to REQ. ir_out=0, busy=0.
  - REQ: ir_out=1. The request is committed: it is held even if the winner is masked or cleared. On ack, go to SERV and clear PEND[cause] if that source is edge mode.
  - SERV: ir_out=0, busy=1, cause held. On eret, go to IDLE.
- Events outside their state are ignored: ack in IDLE/SERV, eret in IDLE/REQ.
- ack and eret both high in REQ: take ack only.
- Synchronous reset in any state: return to IDLE, clear all registers and sync flops, drive ir_out/busy/cause to 0 on the following cycle.

## Timing
- Edge k is the first clock edge at which src[i] is sampled high.
  - PEND[i] is visible after edge k+2.
  - cause is latched at edge k+3, and ir_out is 1 after edge k+3.
  - Minimum latency from source to ir_out is 4 edges, with MASK already set.
- ack sampled high at edge t: ir_out=0, busy=1 after edge t.
- eret sampled high at edge t: busy=0 after edge t. The next request is asserted at the earliest after edge t+1.
- A cfg write at edge t takes effect after edge t. The FSM sees a new MASK at the same edge only in the following cycle.
- cfg_rdata is combinational with zero wait states.

## Test plan
- Reset, then MASK=0x01, EDGE=0x01, pulse src[0] for 1 cycle -> PEND=0x01 two edges after sampling, ir_out=1 with cause=0 one edge later; ack -> ir_out=0, busy=1, PEND=0x00; eret -> busy=0.
- MASK=0xFF, EDGE=0xFF, raise src[5] and src[2] together -> cause=2 first. After ack+eret, cause=5 is requested with no new edge.
- Level mode on src[3] (EDGE=0x00, MASK=0x08), src held high through ack+eret -> a second request with cause=3 follows eret. Drop src[3] -> PEND[3]=0 three edges later and no further request.
- In REQ with cause=1, write MASK=0 and PEND W1C 0x02 -> ir_out stays 1 until ack. Assert ack and eret in the same cycle -> SERV entered, eret ignored.
- Assert rst while in SERV with PEND=0x30 -> after one edge MASK=EDGE=PEND=0, ir_out=0, busy=0, cause=0. Stray ack/eret in IDLE cause no state change.
